// File: rtl/ntt_output_streamer.sv
// rtl/ntt_output_streamer.sv - streams N coefficients out of a synchronous-read RAM as a valid/ready stream
// A 2-entry FIFO with credit-based read issue hides the RAM's one-cycle read latency.
module ntt_output_streamer #(
    parameter int N           = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int BIT_REVERSE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] LP_N    = (ADDR_WIDTH+1)'(N);
    localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(N-1);

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_out_cnt;
    logic                  r_inflight;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;

    logic [1:0]            w_credit;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_last_beat;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    // A pop frees a slot this cycle, so a full credit count may still issue.
    assign w_credit    = r_occ + {1'b0, r_inflight};
    assign m_valid     = (r_occ != 2'd0);
    assign w_pop       = m_valid && m_ready;
    assign w_last_beat = (r_out_cnt == LP_LAST);
    assign w_issue     = (r_state == STREAM) && (r_rd_ptr < LP_N) &&
                         ((w_credit < 2'd2) || ((w_credit == 2'd2) && w_pop));

    assign ram_re = w_issue;
    assign m_data = r_d0;
    assign m_last = m_valid && w_last_beat;
    assign busy   = r_busy;
    assign done   = r_done;

    generate
        if (BIT_REVERSE != 0) begin : g_rev
            assign ram_addr = bitrev(r_rd_ptr[ADDR_WIDTH-1:0]);
        end else begin : g_nat
            assign ram_addr = r_rd_ptr[ADDR_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rd_ptr   <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= STREAM;
                        r_busy    <= 1'b1;
                        r_rd_ptr  <= '0;
                        r_out_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (w_pop && w_last_beat) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Head is always r_d0; r_d1 only holds data while two entries are queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_d0 <= ram_rdata;
                    end else begin
                        r_d1 <= ram_rdata;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_d0 <= r_d1;
                        r_d1 <= ram_rdata;
                    end else begin
                        r_d0 <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_inflight && (r_occ == 2'd2) && !w_pop));
    a_occ_range: assert property (@(posedge clk) disable iff (rst) r_occ <= 2'd2);

endmodule

// File: tb/tb_ntt_output_streamer.sv
// tb/tb_ntt_output_streamer.sv - scoreboard bench for ntt_output_streamer
module tb_ntt_output_streamer;
    localparam int N  = 256;
    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy, done, ram_re, m_valid, m_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] mem [N];

    logic          b_start = 1'b0;
    logic          b_ready = 1'b1;
    logic          b_busy, b_done, b_ram_re, b_valid, b_last;
    logic [AW-1:0] b_ram_addr;
    logic [DW-1:0] b_data;
    logic [DW-1:0] b_rdata;
    logic [DW-1:0] b_mem [N];

    beat_t exp_q[$];
    beat_t bexp_q[$];
    beat_t e, be;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ntt_output_streamer #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_REVERSE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    ntt_output_streamer #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIT_REVERSE(1)) dut_br (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .ram_addr(b_ram_addr), .ram_re(b_ram_re), .ram_rdata(b_rdata),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_last(b_last)
    );

    always @(posedge clk) begin
        if (ram_re)   ram_rdata <= mem[ram_addr];
        if (b_ram_re) b_rdata   <= b_mem[b_ram_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] rev8(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    // Monitor for the natural-order instance
    int cyc = 0, first_hs = 0, last_hs = -10, beats = 0, n_last = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic prev_l;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            beats = 0;
            n_last = 0;
        end else begin
            if (prev_stall && m_valid) begin
                chk("hold_data", m_data, prev_d);
                chk("hold_last", m_last, prev_l);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_last", m_last, e.l);
                end
                if (beats == 0) first_hs = cyc;
                last_hs = cyc;
                beats++;
                if (m_last) n_last++;
            end
            if (done) begin
                chk("done_after_last", cyc, last_hs + 1);
                chk("one_last", n_last, 1);
                chk("beats_per_run", beats, N);
                beats = 0;
                n_last = 0;
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
        end
    end

    // Monitor for the bit-reversed instance
    int b_idx = 0;
    always @(negedge clk) begin
        if (!rst && b_valid && b_ready) begin
            if (bexp_q.size() == 0) begin
                chk("br_unexpected_beat", 1, 0);
            end else begin
                be = bexp_q.pop_front();
                chk("br_beat_data", b_data, be.d);
                chk("br_beat_last", b_last, be.l);
            end
            if (b_idx == 1)   chk("br_beat1", b_data, 128);
            if (b_idx == 2)   chk("br_beat2", b_data, 64);
            if (b_idx == 255) chk("br_beat255", b_data, 255);
            b_idx++;
        end
    end

    task automatic push_exp();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.d = mem[i];
            b.l = (i == N-1);
            exp_q.push_back(b);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
        chk(name, seen, 1);
        m_ready = 1'b1;
    endtask

    task automatic wait_beats(input int target, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (beats >= target) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nre;
        logic [AW-1:0] addrs [4];
        beat_t bb;
        bit seen;

        for (int i = 0; i < N; i++) begin
            mem[i]   = DW'((3 * i) % 3329);
            b_mem[i] = DW'(i);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_re", ram_re, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_m_data", m_data, 0);
        rst = 1'b0;

        // Continuous flow with latency checks
        m_ready = 1'b1;
        push_exp();
        pulse_start();
        @(negedge clk);
        chk("t1_first_re", ram_re, 1);
        chk("t1_first_addr", ram_addr, 0);
        chk("t1_valid_e0", m_valid, 0);
        @(negedge clk);
        chk("t1_valid_e1", m_valid, 0);
        chk("t1_second_addr", ram_addr, 1);
        @(negedge clk);
        chk("t1_valid_e2", m_valid, 1);
        wait_done(600, "t1_done", 1'b0);
        chk("t1_burst_cycles", last_hs - first_hs, N - 1);
        @(posedge clk); #1;
        chk("t1_busy_after", busy, 0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Stall from start
        m_ready = 1'b0;
        push_exp();
        pulse_start();
        nre = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_re) begin
                if (nre < 4) addrs[nre] = ram_addr;
                nre++;
            end
        end
        chk("t3_read_count", nre, 2);
        chk("t3_addr0", addrs[0], 0);
        chk("t3_addr1", addrs[1], 1);
        chk("t3_valid_held", m_valid, 1);
        chk("t3_data_held", m_data, 0);
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        chk("t3_resume_issue", ram_re, 1);
        chk("t3_resume_addr", ram_addr, 2);
        wait_done(600, "t3_done", 1'b0);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Random backpressure
        push_exp();
        pulse_start();
        wait_done(3000, "t4_done", 1'b1);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Start while busy is ignored, then a second identical run
        push_exp();
        pulse_start();
        wait_beats(100, "t5_reach_100");
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(600, "t5_done", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_restart", busy, 0);
        chk("t5_queue_empty", exp_q.size(), 0);
        push_exp();
        pulse_start();
        wait_done(600, "t5_second_done", 1'b0);
        chk("t5_second_empty", exp_q.size(), 0);

        // Reset mid-stream
        push_exp();
        pulse_start();
        wait_beats(50, "t6_reach_50");
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_re", ram_re, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_valid", m_valid, 0);
        push_exp();
        pulse_start();
        @(negedge clk);
        chk("t6_restart_re", ram_re, 1);
        chk("t6_restart_addr", ram_addr, 0);
        wait_done(600, "t6_done", 1'b0);
        chk("t6_queue_empty", exp_q.size(), 0);

        // Bit-reversed readout
        for (int i = 0; i < N; i++) begin
            bb.d = DW'(rev8(AW'(i)));
            bb.l = (i == N-1);
            bexp_q.push_back(bb);
        end
        b_idx = 0;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addrs[i] = b_ram_re ? b_ram_addr : 8'hFF;
        end
        chk("br_addr0", addrs[0], 0);
        chk("br_addr1", addrs[1], 128);
        chk("br_addr2", addrs[2], 64);
        chk("br_addr3", addrs[3], 192);
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (b_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("br_done", seen, 1);
        chk("br_beat_count", b_idx, N);
        chk("br_queue_empty", bexp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
